// File: rtl/noc_pkg.sv
// Shared router types: port count, output-port index and VC index widths.
package noc_pkg;

    localparam int PORT_NUM   = 5;
    localparam int MAX_VC_NUM = 4;

    typedef logic [$clog2(PORT_NUM)-1:0]   port_t;
    typedef logic [$clog2(MAX_VC_NUM)-1:0] vc_idx_t;

endpackage

// File: rtl/rr_arbiter_en.sv
// Round-robin arbiter whose priority pointer moves only when the caller
// confirms the grant was used (update_i); pointer names the top-priority agent.
module rr_arbiter_en #(
    parameter int AGENTS_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AGENTS_NUM-1:0] requests_i,
    input  logic                  update_i,
    output logic [AGENTS_NUM-1:0] grants_o
);

    localparam int PW = (AGENTS_NUM > 1) ? $clog2(AGENTS_NUM) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next_ptr;
    logic          w_found;

    always_comb begin
        int w_idx;
        grants_o   = '0;
        w_next_ptr = r_ptr;
        w_found    = 1'b0;
        w_idx      = 0;
        for (int i = 0; i < AGENTS_NUM; i++) begin
            w_idx = (int'(r_ptr) + i) % AGENTS_NUM;
            if (!w_found && requests_i[w_idx]) begin
                w_found         = 1'b1;
                grants_o[w_idx] = 1'b1;
                w_next_ptr      = PW'((w_idx + 1) % AGENTS_NUM);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (update_i && w_found) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule

// File: rtl/locking_switch_allocator.sv
// Separable input-first switch allocator with wormhole output locking,
// credit masking, and round-robin pointers that move only on final grants.
module locking_switch_allocator import noc_pkg::*; #(
    parameter int PORT_NUM    = noc_pkg::PORT_NUM,
    parameter int VC_NUM      = 2,
    parameter int PACKET_LOCK = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]  request_i,
    input  port_t [VC_NUM-1:0]               out_port_i [PORT_NUM],
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]  tail_i,
    input  logic [PORT_NUM-1:0]              out_ready_i,
    output logic [PORT_NUM-1:0][VC_NUM-1:0]  grant_o
);

    localparam int IPW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
    localparam int VCW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    logic [PORT_NUM-1:0][VC_NUM-1:0] w_elig;
    logic [PORT_NUM-1:0][VC_NUM-1:0] w_s1_req;
    logic [PORT_NUM-1:0][VC_NUM-1:0] w_grant;
    logic [VC_NUM-1:0]               w_cand     [PORT_NUM];
    port_t                           w_cand_out [PORT_NUM];
    logic [VCW-1:0]                  w_cand_vc  [PORT_NUM];
    logic [PORT_NUM-1:0]             w_cand_valid;
    logic [PORT_NUM-1:0]             w_cand_tail;
    logic [PORT_NUM-1:0]             w_in_win;
    logic [PORT_NUM-1:0]             w_s2_req   [PORT_NUM];
    logic [PORT_NUM-1:0]             w_s2_gnt   [PORT_NUM];
    logic [IPW-1:0]                  w_s2_ip    [PORT_NUM];
    logic [PORT_NUM-1:0]             w_out_grant;
    logic [PORT_NUM-1:0]             w_lock_gnt;

    logic [PORT_NUM-1:0]             r_lock_q;
    logic [IPW-1:0]                  r_lock_ip_q [PORT_NUM];
    logic [VCW-1:0]                  r_lock_vc_q [PORT_NUM];
    logic [PORT_NUM-1:0]             r_in_lock_q;

    // Out-of-range targets are treated as ineligible rather than indexing past out_ready_i.
    always_comb begin
        w_elig   = '0;
        w_s1_req = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (request_i[p][v] && (int'(out_port_i[p][v]) < PORT_NUM)) begin
                    w_elig[p][v]   = out_ready_i[out_port_i[p][v]];
                    w_s1_req[p][v] = out_ready_i[out_port_i[p][v]]
                                     && !r_lock_q[out_port_i[p][v]]
                                     && !r_in_lock_q[p];
                end
            end
        end
    end

    genvar gp;
    generate
        for (gp = 0; gp < PORT_NUM; gp++) begin : g_stage1
            rr_arbiter_en #(.AGENTS_NUM(VC_NUM)) u_s1 (
                .clk        (clk),
                .rst        (rst),
                .requests_i (w_s1_req[gp]),
                .update_i   (w_in_win[gp]),
                .grants_o   (w_cand[gp])
            );
        end
        for (gp = 0; gp < PORT_NUM; gp++) begin : g_stage2
            rr_arbiter_en #(.AGENTS_NUM(PORT_NUM)) u_s2 (
                .clk        (clk),
                .rst        (rst),
                .requests_i (w_s2_req[gp]),
                .update_i   (w_out_grant[gp]),
                .grants_o   (w_s2_gnt[gp])
            );
        end
    endgenerate

    always_comb begin
        for (int p = 0; p < PORT_NUM; p++) begin
            w_cand_out[p]   = '0;
            w_cand_vc[p]    = '0;
            w_cand_tail[p]  = 1'b0;
            w_cand_valid[p] = |w_cand[p];
            for (int v = 0; v < VC_NUM; v++) begin
                if (w_cand[p][v]) begin
                    w_cand_out[p]  = out_port_i[p][v];
                    w_cand_vc[p]   = VCW'(v);
                    w_cand_tail[p] = tail_i[p][v];
                end
            end
        end
    end

    // Candidates never target a locked output, so stage 2 needs no extra lock mask.
    always_comb begin
        w_in_win = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            w_s2_req[o]    = '0;
            w_s2_ip[o]     = '0;
            w_out_grant[o] = |w_s2_gnt[o];
            for (int p = 0; p < PORT_NUM; p++) begin
                w_s2_req[o][p] = w_cand_valid[p] && (w_cand_out[p] == port_t'(o));
                if (w_s2_gnt[o][p]) begin
                    w_in_win[p] = 1'b1;
                    w_s2_ip[o]  = IPW'(p);
                end
            end
        end
    end

    always_comb begin
        w_grant = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            w_lock_gnt[o] = r_lock_q[o]
                && w_elig[r_lock_ip_q[o]][r_lock_vc_q[o]]
                && (out_port_i[r_lock_ip_q[o]][r_lock_vc_q[o]] == port_t'(o));
        end
        for (int p = 0; p < PORT_NUM; p++) begin
            if (w_in_win[p]) begin
                w_grant[p] = w_cand[p];
            end
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            if (w_lock_gnt[o]) begin
                w_grant[r_lock_ip_q[o]][r_lock_vc_q[o]] = 1'b1;
            end
        end
    end

    assign grant_o = rst ? w_grant : '0;

    // A lock is taken by a non-tail winner and released only by the owner's tail grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lock_q    <= '0;
            r_in_lock_q <= '0;
            for (int o = 0; o < PORT_NUM; o++) begin
                r_lock_ip_q[o] <= '0;
                r_lock_vc_q[o] <= '0;
            end
        end else if (PACKET_LOCK != 0) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                if (r_lock_q[o]) begin
                    if (w_lock_gnt[o] && tail_i[r_lock_ip_q[o]][r_lock_vc_q[o]]) begin
                        r_lock_q[o]                 <= 1'b0;
                        r_in_lock_q[r_lock_ip_q[o]] <= 1'b0;
                    end
                end else if (w_out_grant[o] && !w_cand_tail[w_s2_ip[o]]) begin
                    r_lock_q[o]             <= 1'b1;
                    r_lock_ip_q[o]          <= w_s2_ip[o];
                    r_lock_vc_q[o]          <= w_cand_vc[w_s2_ip[o]];
                    r_in_lock_q[w_s2_ip[o]] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_locking_switch_allocator.sv
// Directed bench for locking_switch_allocator: a locking and a flit-by-flit
// instance share stimulus; grants are compared with hand-computed vectors.
module tb_locking_switch_allocator;
    import noc_pkg::*;

    localparam int P = 5;
    localparam int V = 2;

    logic                 clk;
    logic                 rst_n;
    logic [P-1:0][V-1:0]  request;
    logic [P-1:0][V-1:0]  tail;
    port_t [V-1:0]        out_port [P];
    logic [P-1:0]         out_ready;
    logic [P-1:0][V-1:0]  grant;
    logic [P-1:0][V-1:0]  grant_nl;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    locking_switch_allocator #(.PORT_NUM(P), .VC_NUM(V), .PACKET_LOCK(1)) dut (
        .clk         (clk),
        .rst         (rst_n),
        .request_i   (request),
        .out_port_i  (out_port),
        .tail_i      (tail),
        .out_ready_i (out_ready),
        .grant_o     (grant)
    );

    locking_switch_allocator #(.PORT_NUM(P), .VC_NUM(V), .PACKET_LOCK(0)) dut_nl (
        .clk         (clk),
        .rst         (rst_n),
        .request_i   (request),
        .out_port_i  (out_port),
        .tail_i      (tail),
        .out_ready_i (out_ready),
        .grant_o     (grant_nl)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        request   = '0;
        tail      = '0;
        out_ready = '1;
        for (int p = 0; p < P; p++) begin
            for (int v = 0; v < V; v++) begin
                out_port[p][v] = '0;
            end
        end
    endtask

    task automatic drive(input int p, input int v, input int o, input logic t);
        request[p][v]  = 1'b1;
        out_port[p][v] = port_t'(o);
        tail[p][v]     = t;
    endtask

    function automatic logic [P*V-1:0] g(input int p, input int v);
        logic [P*V-1:0] r;
        r = '0;
        r[p*V+v] = 1'b1;
        return r;
    endfunction

    // scoreboard
    task automatic check(input string tag, input logic [P*V-1:0] obs, input logic [P*V-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        request = '1;
        tail    = '1;
        for (int p = 0; p < P; p++) begin
            for (int v = 0; v < V; v++) begin
                out_port[p][v] = port_t'(2);
            end
        end
        #1;
        check("reset_grant", grant, '0);
        check("reset_grant_nl", grant_nl, '0);
        tick();
        check("reset_grant_held", grant, '0);

        // Release reset away from the edge, then in0/in1 alternate on out2.
        rst_n = 1'b1;
        clear_inputs();
        drive(0, 0, 2, 1'b1);
        drive(1, 0, 2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("fair_c%0d", i), grant, (i % 2 == 0) ? g(0, 0) : g(1, 0));
            check($sformatf("fair_nl_c%0d", i), grant_nl, (i % 2 == 0) ? g(0, 0) : g(1, 0));
            tick();
        end

        // Packet lock: in0 holds out3 head..tail; in1 waits until the cycle after tail.
        clear_inputs();
        drive(1, 0, 3, 1'b1);
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 3, (c == 3));
            #1;
            check($sformatf("lock_c%0d", c), grant, g(0, 0));
            tick();
        end
        request[0][0] = 1'b0;
        #1;
        check("lock_release_c4", grant, g(1, 0));
        tick();

        // Credit masking on out3.
        clear_inputs();
        out_ready[3] = 1'b0;
        drive(0, 0, 3, 1'b1);
        drive(0, 1, 1, 1'b1);
        #1;
        check("credit_mask", grant, g(0, 1));
        tick();
        out_ready[3] = 1'b1;
        #1;
        check("credit_return", grant, g(0, 0));
        tick();

        // Stage-1 pointer holds when the candidate loses stage 2.
        clear_inputs();
        drive(0, 0, 2, 1'b1);
        drive(0, 1, 2, 1'b1);
        drive(4, 0, 2, 1'b1);
        #1;
        check("ptr_hold_s2_loss", grant, g(4, 0));
        tick();
        request[4][0] = 1'b0;
        #1;
        check("ptr_hold_reoffer", grant, g(0, 1));
        tick();

        // Lock out3 to in0.vc0, then reset mid-packet.
        clear_inputs();
        drive(0, 0, 3, 1'b0);
        #1;
        check("midlock_head", grant, g(0, 0));
        tick();
        drive(1, 0, 3, 1'b0);
        #1;
        check("midlock_body", grant, g(0, 0));
        tick();
        rst_n = 1'b0;
        #1;
        check("midlock_in_reset", grant, '0);
        check("midlock_in_reset_nl", grant_nl, '0);
        #1;
        rst_n = 1'b1;
        request[0][0] = 1'b0;
        #1;
        check("midlock_after_reset", grant, g(1, 0));
        check("midlock_after_reset_nl", grant_nl, g(1, 0));
        tick();

        // Flit-by-flit instance lets in1 in while in0 is mid-packet.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        clear_inputs();
        drive(0, 0, 3, 1'b0);
        drive(1, 0, 3, 1'b1);
        #1;
        check("nolock_head", grant, g(0, 0));
        check("nolock_head_nl", grant_nl, g(0, 0));
        tick();
        #1;
        check("nolock_body_locked", grant, g(0, 0));
        check("nolock_body_nl", grant_nl, g(1, 0));
        tick();

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/locking_switch_allocator.md
# locking_switch_allocator

Parametrised separable input-first switch allocator for the virtual-channel router, one level up from the basic allocator. It adds wormhole packet locking, per-output credit masking and round-robin pointers that advance only on final grants. It sits between the per-port VC buffers/route computation and the crossbar, and produces a one-hot-per-row grant matrix every cycle.

## Interface
- `PORT_NUM`, default `noc_pkg::PORT_NUM` (5): number of router ports.
- `VC_NUM`, default 2: VCs per input port, ≥1.
- `PACKET_LOCK`, default 1: 1 holds an output for a packet until its tail is granted; 0 allocates flit-by-flit.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `request_i`  in  [PORT_NUM][VC_NUM]  VC has a flit ready to traverse.
- `out_port_i`  in  port_t [VC_NUM] × PORT_NUM (unpacked)  target output per VC.
- `tail_i`  in  [PORT_NUM][VC_NUM]  requesting flit is a tail; head+tail counts as tail.
- `out_ready_i`  in  [PORT_NUM]  downstream of output has ≥1 credit.
- `grant_o`  out  [PORT_NUM][VC_NUM]  combinational grant matrix.

## Operation
- Eligible(p,v) = `request_i[p][v]` && `out_ready_i[out_port_i[p][v]]`.
- State per output o:
  - `lock_q[o]`
  - `lock_ip_q[o]`, width $clog2(PORT_NUM)
  - `lock_vc_q[o]`, width max(1,$clog2(VC_NUM))
- State per input p: `in_lock_q[p]`.
- Locked output o owned by (p,v): granted to (p,v) iff (p,v) is eligible; otherwise o is idle that cycle. Input p makes no other request.
- Stage 1, each unlocked input: round-robin over eligible VCs whose target output is unlocked. The result is a one-hot candidate.
- Stage 2, each unlocked output: round-robin over the inputs whose candidate targets it.
- `grant_o[p][v]`=1 iff (p,v) wins both stages, or (p,v) is the eligible owner of a locked output.
- Invariants:
  - ≤1 grant per input row.
  - ≤1 grant per output.
  - No grant without eligibility.
- Round-robin convention:
  - Pointer = highest-priority index.
  - After a grant to index k, pointer ← (k+1) mod N.
- Stage-1 pointer of input p advances only if its candidate receives the final grant.
- Stage-2 pointer of output o advances only when o grants.
- Neither pointer moves during locked grants.
- Lock update at the clock edge (PACKET_LOCK=1):
  - Grant to (p,v) with `tail_i`=0 on unlocked o: set lock, owner (p,v), set `in_lock_q[p]`.
  - Grant to owner with `tail_i`=1: clear both locks.
- PACKET_LOCK=0: lock registers are held at 0.

## Timing
- `grant_o` is combinational from inputs and state; zero-cycle latency.
- State updates at the rising edge following the grant.
- Reset (`rst`=0, asynchronous):
  - All pointers ← 0.
  - All locks ← 0.
  - `grant_o` forced to all-zero while `rst`=0.
- Released lock becomes usable in the cycle after the tail grant; no same-cycle hand-over.
- `out_ready_i` low on a locked output: lock is held and no grant is made; the owner resumes when ready returns.
- Owner withdraws its request mid-packet: lock is held indefinitely (no timeout).
- Reset asserted mid-packet: lock is dropped immediately. Upstream must also flush.
- `out_port_i` and `tail_i` are don't-care when the matching `request_i`=0.

## Structure
- `noc_pkg` provides `PORT_NUM` and `port_t`.
- Add `noc_pkg` typedef `vc_idx_t` sized for the maximum VC_NUM.
- One sub-module, `rr_arbiter_en #(AGENTS_NUM)`, used by both stages:
  - Ports: `clk`, `rst`, `requests_i`, `update_i`, `grants_o`.
  - Pointer advances only when `update_i`=1.
  - Reset and polarity match this block.
- Top level contains: eligibility masking, candidate-to-output routing, grant merge, lock registers.

## Test plan
1. **Reset:** `rst`=0, all requests=1, all ready=1 → `grant_o`=0. Release reset; in0 and in1 VC0 both → out2, tail=1 → first cycle grants (0,0).
2. **Fairness:** in0.vc0 and in1.vc0 → out2, tail=1, held for 4 cycles → grants in0, in1, in0, in1.
3. **Packet lock:**
   - in0.vc0 sends head (tail=0) → out3 at cycle 0, body at cycles 1–2, tail at cycle 3.
   - in1.vc0 → out3 continuously.
   - Required: in0 granted cycles 0–3; in1 first granted at cycle 4.
4. **Credit masking:** `out_ready_i[3]`=0; in0.vc0 → out3, in0.vc1 → out1 → `grant_o[0]`=2'b10. Raise ready → vc0 is granted on its next request.
5. **Pointer hold:**
   - in0.vc0 and in0.vc1 → out2; in4.vc0 → out2 wins stage 2.
   - Required: in0's stage-1 pointer is unchanged, so in0 re-offers the same VC next cycle.
6. **Reset mid-lock, then PACKET_LOCK=0:**
   - Lock out3 to in0.vc0, pulse `rst` → in1 is granted out3 on the first cycle after release.
   - With PACKET_LOCK=0, a head flit (tail=0) on out3 does not block other inputs.
